spi_master_ctrl: RTL

//  Single-clock SPI master. Accepts a command and byte from the system bus and serialises it

---
 rtl/spi_master_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// Single-clock SPI master: serialises {cmd,wdata} onto SS_n/MOSI and captures read data from MISO.
// Optional SPI_AUTO_READ_EN: an rd-addr start automatically chains an rd-data frame.
module spi_master_ctrl #(
    parameter int RD_LAT  = 2,
    parameter int GAP_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_DATA, S_WAIT, S_RX, S_GAP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  frame_q, frame_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  bit_idx;
`ifdef SPI_AUTO_READ_EN
    logic        auto_q, auto_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        frame_d = frame_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
`ifdef SPI_AUTO_READ_EN
        auto_d  = auto_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    frame_d = {cmd, wdata};
`ifdef SPI_AUTO_READ_EN
                    auto_d  = (cmd == 2'b10);
`endif
                end
            end
            S_SETUP: begin
                state_d = S_CMD;
                cnt_d   = '0;
            end
            S_CMD: begin
                if (cnt_q == 8'd2) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd7) begin
                    cnt_d = '0;
                    if (frame_q[9:8] == 2'b11) state_d = (RD_LAT == 0) ? S_RX : S_WAIT;
                    else                       state_d = S_GAP;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RX;
                    cnt_d   = '0;
                end
            end
            S_RX: begin
                // MISO is only looked at here, so undriven levels elsewhere never reach rx_q
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 8'd7) begin
                    rdata_d = {rx_q[6:0], MISO};
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef SPI_AUTO_READ_EN
                    if (auto_q) begin
                        state_d = S_SETUP;
                        frame_d = {2'b11, 8'h00};
                        auto_d  = 1'b0;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output flops are loaded with the values belonging to the state being entered
        bit_idx = 3'd7 - cnt_d[2:0];
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_GAP) && (state_d == S_IDLE);
        case (state_d)
            S_SETUP, S_WAIT, S_RX: ss_n_d = 1'b0;
            S_CMD: begin
                ss_n_d = 1'b0;
                mosi_d = (cnt_d == 8'd2) ? frame_d[8] : frame_d[9];
            end
            S_DATA: begin
                ss_n_d = 1'b0;
                mosi_d = frame_d[bit_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
`ifdef SPI_AUTO_READ_EN
            auto_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef SPI_AUTO_READ_EN
            auto_q  <= auto_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        rx_q    <= rx_d;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign SS_n  = ss_n_q;
    assign MOSI  = mosi_q;

endmodule
